// File: rtl/rs232_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding the RS232 FIFO transmit queue.
// Clients hand over bytes via valid/ready; bytes go to the FIFO via Send/Busy.
module rs232_tx_arbiter #(
   parameter int unsigned            Requesters  = 4,
   parameter int unsigned            GrantBits   = 2,
   parameter logic [9:0]             FullLevel   = 10'd1016,
   parameter int unsigned            TimeoutBits = 16,
   parameter logic [TimeoutBits-1:0] Timeout     = 16'd50000
) (
   input  logic                    Clk,
   input  logic                    nReset,
   input  logic [Requesters-1:0]   Req_Valid,
   input  logic [8*Requesters-1:0] Req_Data,
   input  logic [Requesters-1:0]   Req_Last,
   output logic [Requesters-1:0]   Req_Ready,
   output logic [7:0]              Fifo_TxData,
   output logic                    Fifo_Send,
   input  logic                    Fifo_Busy,
   input  logic [9:0]              Fifo_TxCount,
   output logic [GrantBits-1:0]    Grant,
   output logic                    Locked,
   output logic                    TimeoutPulse,
   output logic [1:0]              Dbg_State
);

   // Client handshake: a byte moves on the cycle after the arbiter samples
   // Req_Valid=1 together with FIFO space; Req_Ready pulses for exactly that
   // cycle and Req_Data/Req_Last are only sampled on the accepting edge.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2,
      S_NEXT = 2'd3
   } state_t;

   localparam logic [TimeoutBits-1:0] TimeoutLast = Timeout - TimeoutBits'(1);
   localparam logic [GrantBits-1:0]   GrantReset  = GrantBits'(Requesters - 1);

   state_t                  state_q, state_d;
   logic [GrantBits-1:0]    grant_q, grant_d;
   logic [7:0]              txdata_q, txdata_d;
   logic                    send_q, send_d;
   logic [Requesters-1:0]   ready_q, ready_d;
   logic                    locked_q, locked_d;
   logic                    tpulse_q, tpulse_d;
   logic                    last_q, last_d;
   logic [TimeoutBits-1:0]  cnt_q, cnt_d;

   logic [7:0]              req_byte [Requesters];
   logic                    space;
   logic                    sel_found;
   logic [GrantBits-1:0]    sel_idx;
   logic [GrantBits-1:0]    cand;
   logic                    accept;
   logic [GrantBits-1:0]    acc_idx;

   for (genvar i = 0; i < Requesters; i++) begin : g_byte
      assign req_byte[i] = Req_Data[8*i +: 8];
   end

   assign space = (Fifo_TxCount < FullLevel);

   // Search starts one past the last grant so the previous owner ends up last.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = grant_q;
      cand      = '0;
      for (int unsigned k = 1; k <= Requesters; k++) begin
         cand = GrantBits'((32'(grant_q) + k) % Requesters);
         if (!sel_found && Req_Valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      txdata_d = txdata_q;
      send_d   = send_q;
      ready_d  = '0;
      locked_d = locked_q;
      tpulse_d = 1'b0;
      last_d   = last_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      acc_idx  = grant_q;

      case (state_q)
         S_IDLE: begin
            if (sel_found && space) begin
               accept  = 1'b1;
               acc_idx = sel_idx;
            end
         end
         S_SEND: begin
            if (Fifo_Busy) begin
               send_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!Fifo_Busy) begin
               if (last_q) begin
                  locked_d = 1'b0;
                  state_d  = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            if (Req_Valid[grant_q] && space) begin
               accept = 1'b1;
            end else if (cnt_q == TimeoutLast) begin
               // Grant is kept so the stalled client loses priority next round.
               tpulse_d = 1'b1;
               locked_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + TimeoutBits'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         grant_d          = acc_idx;
         txdata_d         = req_byte[acc_idx];
         ready_d[acc_idx] = 1'b1;
         last_d           = Req_Last[acc_idx];
         send_d           = 1'b1;
         locked_d         = 1'b1;
         state_d          = S_SEND;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q  <= S_IDLE;
         grant_q  <= GrantReset;
         txdata_q <= '0;
         send_q   <= 1'b0;
         ready_q  <= '0;
         locked_q <= 1'b0;
         tpulse_q <= 1'b0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         txdata_q <= txdata_d;
         send_q   <= send_d;
         ready_q  <= ready_d;
         locked_q <= locked_d;
         tpulse_q <= tpulse_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Req_Ready    = ready_q;
   assign Fifo_TxData  = txdata_q;
   assign Fifo_Send    = send_q;
   assign Grant        = grant_q;
   assign Locked       = locked_q;
   assign TimeoutPulse = tpulse_q;
   assign Dbg_State    = state_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter with a one-cycle-latency FIFO Busy model.
module tb_rs232_tx_arbiter;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_NEXT = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        send;
   logic        busy;
   logic [9:0]  tx_count;
   logic [1:0]  grant;
   logic        locked;
   logic        tpulse;
   logic [1:0]  dbg_state;
   logic        busy_force;

   int n_checks = 0;
   int n_pass = 0;
   int ready_total = 0;
   int send_rises = 0;
   logic prev_send = 1'b0;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   rs232_tx_arbiter #(
      .Requesters (4),
      .GrantBits  (2),
      .FullLevel  (10'd1016),
      .TimeoutBits(16),
      .Timeout    (16'd8)
   ) dut (
      .Clk         (clk),
      .nReset      (rst_n),
      .Req_Valid   (req_valid),
      .Req_Data    (req_data),
      .Req_Last    (req_last),
      .Req_Ready   (req_ready),
      .Fifo_TxData (tx_data),
      .Fifo_Send   (send),
      .Fifo_Busy   (busy),
      .Fifo_TxCount(tx_count),
      .Grant       (grant),
      .Locked      (locked),
      .TimeoutPulse(tpulse),
      .Dbg_State   (dbg_state)
   );

   // FIFO model: Busy follows Send one cycle later unless forced high.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= 1'b0;
      else        busy <= busy_force | send;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor: records each delivered byte as {grant, data}.
   always @(negedge clk) begin
      logic [3:0] one_hot;
      if (rst_n) begin
         if (send && !prev_send) begin
            got_q.push_back({grant, tx_data});
            send_rises++;
            one_hot = 4'b0001 << grant;
            check("ready_with_send", {28'd0, req_ready}, {28'd0, one_hot});
         end
         if (req_ready != 4'b0000) begin
            ready_total++;
            check("ready_onehot", $countones(req_ready), 1);
         end
      end
      prev_send = send;
   end

   task automatic wait_idle(input int budget);
      int i = 0;
      while (!(dbg_state == ST_IDLE && !busy && !send) && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (i >= budget) check("wait_idle_timeout", 0, 1);
   endtask

   task automatic compare_queue(input string tag);
      logic [9:0] g;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         if (got_q.size() > 0) g = got_q.pop_front();
         else g = 10'h3ff;
         check(tag, {22'd0, g}, {22'd0, exp_q.pop_front()});
      end
      got_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_ready, snap_send, k, i, send_cycles;
      bit done;
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      tx_count = '0; busy_force = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", {28'd0, req_ready}, 0);
      check("rst_txdata", {24'd0, tx_data}, 0);
      check("rst_send", {31'd0, send}, 0);
      check("rst_grant", {30'd0, grant}, 3);
      check("rst_locked", {31'd0, locked}, 0);
      check("rst_tpulse", {31'd0, tpulse}, 0);
      rst_n = 1'b1;

      // Reset asserted while a byte is in SEND.
      req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[15:8] = 8'h55;
      i = 0;
      do begin @(negedge clk); i++; end while (!send && i < 20);
      check("midsend_reached", {31'd0, send}, 1);
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_send", {31'd0, send}, 0);
      check("midrst_txdata", {24'd0, tx_data}, 0);
      check("midrst_grant", {30'd0, grant}, 3);
      check("midrst_locked", {31'd0, locked}, 0);
      check("midrst_state", {30'd0, dbg_state}, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      snap_ready = ready_total; snap_send = send_rises;
      repeat (10) @(negedge clk);
      check("idle_no_ready", ready_total, snap_ready);
      check("idle_no_send", send_rises, snap_send);
      check("idle_grant", {30'd0, grant}, 3);

      // Round-robin over four single-byte clients.
      req_data = {8'h43, 8'h32, 8'h21, 8'h10};
      req_last = 4'hf;
      req_valid = 4'hf;
      i = 0;
      while (got_q.size() < 5 && i < 100) begin @(negedge clk); i++; end
      req_valid = '0;
      wait_idle(50);
      exp_q.push_back({2'd0, 8'h10});
      exp_q.push_back({2'd1, 8'h21});
      exp_q.push_back({2'd2, 8'h32});
      exp_q.push_back({2'd3, 8'h43});
      exp_q.push_back({2'd0, 8'h10});
      compare_queue("rr");

      // Packet lock: client 2 sends A0..A2 while client 0 waits.
      req_data = '0; req_last = '0;
      req_data[23:16] = 8'hA0;
      req_data[7:0] = 8'h0C; req_last[0] = 1'b1;
      req_valid = 4'b0101;
      k = 0; done = 0; i = 0;
      while (!done && i < 300) begin
         @(negedge clk);
         i++;
         if (req_ready[2]) begin
            check("lock_on_accept", {31'd0, locked}, 1);
            k++;
            if (k == 3) req_valid[2] = 1'b0;
            else begin
               req_data[23:16] = 8'hA0 + 8'(k);
               req_last[2] = (k == 2);
            end
         end else if (req_ready[0]) begin
            check("lock_order", k, 3);
            req_valid[0] = 1'b0;
            done = 1;
         end else if (k > 0 && k < 3) begin
            check("lock_held", {31'd0, locked}, 1);
         end
      end
      check("lock_done", {31'd0, done}, 1);
      wait_idle(50);
      exp_q.push_back({2'd2, 8'hA0});
      exp_q.push_back({2'd2, 8'hA1});
      exp_q.push_back({2'd2, 8'hA2});
      exp_q.push_back({2'd0, 8'h0C});
      compare_queue("lock");

      // Back-pressure at the full threshold.
      tx_count = 10'd1016;
      req_data[15:8] = 8'h77; req_last[1] = 1'b1; req_valid = 4'b0010;
      snap_ready = ready_total;
      repeat (12) @(negedge clk);
      check("bp_no_ready", ready_total, snap_ready);
      check("bp_no_send", {31'd0, send}, 0);
      tx_count = 10'd1015;
      @(negedge clk);
      check("bp_send", {31'd0, send}, 1);
      check("bp_ready", {28'd0, req_ready}, 4'b0010);
      check("bp_data", {24'd0, tx_data}, 8'h77);
      req_valid = '0; tx_count = '0;
      wait_idle(50);
      got_q.delete();

      // Lock timeout: client 3 sends a non-last byte then stalls.
      req_data[31:24] = 8'h3C; req_last = '0; req_valid = 4'b1000;
      i = 0;
      while (dbg_state != ST_NEXT && i < 50) begin
         @(negedge clk);
         i++;
         if (req_ready[3]) req_valid[3] = 1'b0;
      end
      check("to_reached_next", {30'd0, dbg_state}, ST_NEXT);
      for (int n = 0; n < 8; n++) begin
         check("to_no_pulse", {31'd0, tpulse}, 0);
         check("to_locked", {31'd0, locked}, 1);
         @(negedge clk);
      end
      check("to_pulse", {31'd0, tpulse}, 1);
      check("to_unlocked", {31'd0, locked}, 0);
      check("to_grant_kept", {30'd0, grant}, 3);
      check("to_state", {30'd0, dbg_state}, ST_IDLE);
      @(negedge clk);
      check("to_pulse_once", {31'd0, tpulse}, 0);
      got_q.delete();
      req_data[7:0] = 8'h0A; req_data[31:24] = 8'h3D; req_last = 4'b1001;
      req_valid = 4'b1001;
      i = 0;
      while (req_ready == 4'b0000 && i < 20) begin @(negedge clk); i++; end
      check("to_next_client", {28'd0, req_ready}, 4'b0001);
      req_valid = '0;
      wait_idle(50);
      exp_q.push_back({2'd0, 8'h0A});
      compare_queue("to_next");

      // Busy already high before Send rises.
      busy_force = 1'b1;
      repeat (2) @(negedge clk);
      check("early_busy_high", {31'd0, busy}, 1);
      snap_ready = ready_total;
      req_data[23:16] = 8'h99; req_last = 4'b0100; req_valid = 4'b0100;
      send_cycles = 0; done = 0; i = 0;
      while (!done && i < 30) begin
         @(negedge clk);
         i++;
         if (req_ready[2]) req_valid[2] = 1'b0;
         if (send) send_cycles++;
         else if (send_cycles > 0) begin
            busy_force = 1'b0;
            done = 1;
         end
      end
      busy_force = 1'b0;
      wait_idle(50);
      repeat (5) @(negedge clk);
      check("early_send_len", send_cycles, 1);
      check("early_ready_once", ready_total - snap_ready, 1);
      check("early_unlocked", {31'd0, locked}, 0);
      exp_q.push_back({2'd2, 8'h99});
      compare_queue("early");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
